uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//   Serial receive engine for the UART peripheral: synchronises the uart_rx pin and detects
//   start bits. Samples 8N1 frames LSB-first at mid-bit and delivers each byte as
//   rx_byte_o / rx_over_o, which the UART register block loads into its RX data register
//   and RX-full status bit. Sits between the pad and the UART register block; one instance per UART.
// PARAMETERS
//   DIV_W        16  width of the bit-period divisor (clocks per bit)
//   SYNC_STAGES  2   flip-flop stages on rx_i before any use (>=2)
// PORTS
//   clk_i        in   1      system clock
//   rst_n_i      in   1      reset, asynchronous assert, active-low
//   en_i         in   1      receiver enable (UART CTRL bit 1)
//   baud_div_i   in   DIV_W  clocks per bit (UART BAUD register, CLK_FREQ/UART_BPS at reset)
//   rx_i         in   1      raw serial line, idle high, asynchronous to clk_i
//   rx_byte_o    out  8      last correctly framed byte; held until next good frame
//   rx_over_o    out  1      1-cycle pulse: rx_byte_o just updated
//   frame_err_o  out  1      1-cycle pulse: stop bit sampled low, byte discarded
//   busy_o       out  1      high while state != IDLE
// BEHAVIOUR
//   Reset: state IDLE, rx_byte_o=0, rx_over_o=0, frame_err_o=0, busy_o=0, all sync FFs and
//     the previous-sample FF set to 1 (line idle). Reset mid-frame aborts and emits no pulses.
//   rxs = rx_i after SYNC_STAGES FFs; fall = prev_rxs & ~rxs.
//   Divisor: latched into div_q on leaving IDLE; baud_div_i changes mid-frame have no effect.
//     A latched value < 2 is forced to 2.
//   Counter cnt (DIV_W bits) counts down; a sample point is the cycle where cnt==0.
//   FSM (next-state registered):
//     IDLE : en_i & fall -> START, cnt=(div>>1)-1. Otherwise stay.
//     START: at sample: rxs==0 -> DATA, cnt=div-1, bit_idx=0; rxs==1 -> IDLE (glitch reject).
//     DATA : at sample: shreg={rxs,shreg[7:1]}, cnt=div-1; after bit_idx==7 -> STOP, else bit_idx++.
//     STOP : at sample: rxs==1 -> rx_byte_o<=shreg, rx_over_o=1 for next cycle; rxs==0 ->
//            frame_err_o=1 for next cycle, rx_byte_o unchanged. Either case -> IDLE.
//   Timing: with the fall seen in cycle T0, the stop sample is at T0+(div>>1)+9*div and the
//     pulse is visible at T0+(div>>1)+9*div+1. Add SYNC_STAGES cycles of pin-to-rxs latency.
//   rx_over_o and frame_err_o are never high together; each pulses at most once per frame.
//   en_i low in any non-IDLE state -> IDLE next cycle, no pulse, rx_byte_o kept.
//   After a low stop bit (break), no new frame starts until rxs returns high and then falls.
//   A fall during the trailing half stop bit of a good frame is accepted, so back-to-back
//     frames are received without gaps.
//   No FIFO: the consumer captures rx_byte_o on rx_over_o; overrun is the consumer's concern.
// STRUCTURE
//   uart_pkg (shared with the UART register block): typedef enum logic [1:0]
//     {RX_IDLE, RX_START, RX_DATA, RX_STOP}; localparam UART_DATA_BITS=8; default DIV_W.
//   One sub-module: sync_ff #(.STAGES, .RST_VAL(1'b1)), a generic bit synchroniser reused
//     for other pad inputs. Counter, FSM and shift register stay inline.
// TESTING
//   div=16, en=1, send 0xA5 8N1 -> one rx_over_o pulse at fall+8+144+1+2 cycles,
//     rx_byte_o=0xA5, frame_err_o never high, busy_o low after the pulse.
//   div=16, 4-cycle low glitch on idle line -> START rejects at the half-bit sample,
//     back to IDLE, no pulses, rx_byte_o unchanged.
//   After 0xA5, send 0x3C with stop bit low, then hold the line low 40 bits -> one
//     frame_err_o pulse, rx_byte_o stays 0xA5, no further activity until line high then low.
//   div=4 (and div=0 forced to 2), back-to-back 0x00,0xFF,0x55 with no idle gap -> three
//     rx_over_o pulses with correct bytes in order.
//   Mid-frame: change baud_div_i 16->8 -> byte still correct; drop en_i at bit 3 -> IDLE,
//     no pulse; assert rst_n_i low at bit 5 -> all outputs 0 immediately, no pulse after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants.
// Also imported by the UART register block.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_DIV_W     = 16;

endpackage

// File: rtl/sync_ff.sv
// Generic single-bit synchroniser for asynchronous pad inputs; the reset value is a parameter
// so that idle-high lines do not show a false edge when reset is released.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sync_q <= {STAGES{RST_VAL}};
        else          sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receive engine: synchronises the line, finds start bits, samples each bit at
// mid-period and reports good bytes (rx_over_o) or bad stop bits (frame_err_o).
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIV_W       = UART_DIV_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             rx_i,
    output logic [7:0]       rx_byte_o,
    output logic             rx_over_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    logic rxs;
    logic prev_rxs_q;
    logic fall;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (rx_i),
        .q_o     (rxs)
    );

    assign fall = prev_rxs_q & ~rxs;

    rx_state_e                 state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [DIV_W-1:0]          cnt_q, cnt_d;
    logic [DIV_W-1:0]          div_in;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [UART_DATA_BITS-1:0] byte_q, byte_d;
    logic                      over_q, over_d;
    logic                      ferr_q, ferr_d;
    logic                      sample;

    // Divisors below 2 would give a zero half-bit count; clamp so timing stays well defined.
    assign div_in = (baud_div_i < DIV_W'(2)) ? DIV_W'(2) : baud_div_i;
    assign sample = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RX_IDLE;
            prev_rxs_q <= 1'b1;
            div_q      <= DIV_W'(2);
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            byte_q     <= '0;
            over_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_rxs_q <= rxs;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            byte_q     <= byte_d;
            over_q     <= over_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        byte_d    = byte_q;
        over_d    = 1'b0;
        ferr_d    = 1'b0;
        if (state_q != RX_IDLE && !en_i) begin
            state_d = RX_IDLE;
        end else begin
            unique case (state_q)
                RX_IDLE: begin
                    if (en_i && fall) begin
                        state_d = RX_START;
                        div_d   = div_in;
                        cnt_d   = (div_in >> 1) - DIV_W'(1);
                    end
                end
                RX_START: begin
                    if (!sample) begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end else if (!rxs) begin
                        state_d   = RX_DATA;
                        cnt_d     = div_q - DIV_W'(1);
                        bit_idx_d = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (!sample) begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end else begin
                        shreg_d = {rxs, shreg_q[UART_DATA_BITS-1:1]};
                        cnt_d   = div_q - DIV_W'(1);
                        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = RX_STOP;
                        else bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (!sample) begin
                        cnt_d = cnt_q - DIV_W'(1);
                    end else begin
                        // Returning to IDLE at mid stop bit lets the next start edge be caught.
                        state_d = RX_IDLE;
                        if (rxs) begin
                            byte_d = shreg_q;
                            over_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q != RX_IDLE);
        rx_byte_o   = byte_q;
        rx_over_o   = over_q;
        frame_err_o = ferr_q;
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: stimulus pushes expected pulses into a scoreboard queue,
// an independent monitor pops and compares each rx_over_o / frame_err_o pulse.
module tb_uart_rx_core;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] baud_div;
    logic        rx;
    logic [7:0]  rx_byte;
    logic        rx_over;
    logic        frame_err;
    logic        busy;

    uart_rx_core #(.DIV_W(16), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .baud_div_i  (baud_div),
        .rx_i        (rx),
        .rx_byte_o   (rx_byte),
        .rx_over_o   (rx_over),
        .frame_err_o (frame_err),
        .busy_o      (busy)
    );

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   hook_bit = -1;
    int   hook_act = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rx_over || frame_err) begin
            exp_t e;
            chk("pulse_exclusive", {31'd0, rx_over & frame_err}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse over=%0b err=%0b byte=%0h (cycle %0d)",
                         rx_over, frame_err, rx_byte, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                chk("pulse_byte", {24'd0, rx_byte}, {24'd0, e.data});
                if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_hook(input int act);
        case (act)
            1: baud_div = 16'd8;
            2: en = 1'b0;
            3: begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_byte", {24'd0, rx_byte}, 32'd0);
                chk("rst_mid_over", {31'd0, rx_over}, 32'd0);
                chk("rst_mid_ferr", {31'd0, frame_err}, 32'd0);
                chk("rst_mid_busy", {31'd0, busy}, 32'd0);
            end
            4: rst_n = 1'b1;
            default: ;
        endcase
    endtask

    // Entered and left 1 time unit after a posedge; frames chain with no idle gap.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int div,
                              input bit exp_pulse, input bit exp_err,
                              input logic [7:0] exp_byte, input int lat);
        logic [9:0] fr;
        exp_t       e;
        fr = {stop, b, 1'b0};
        if (exp_pulse) begin
            e.err  = exp_err;
            e.data = exp_byte;
            e.cyc  = (lat >= 0) ? cyc + lat : -1;
            sb.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == hook_bit) do_hook(hook_act);
            if (i == hook_bit + 2 && hook_act == 3) do_hook(4);
            rx = fr[i];
            tick(div);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        baud_div = 16'd16;
        rx       = 1'b1;
        tick(3);
        chk("reset_byte", {24'd0, rx_byte}, 32'd0);
        chk("reset_over", {31'd0, rx_over}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // 0xA5 at div=16: pulse 2 sync + 1 fall + 8 half + 144 bits = 155 cycles after start edge
        send_frame(8'hA5, 1'b1, 16, 1'b1, 1'b0, 8'hA5, 155);
        tick(20);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);
        chk("a5_byte_held", {24'd0, rx_byte}, 32'hA5);

        // 4-cycle glitch: START entered then rejected at the half-bit sample
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2);
        chk("glitch_busy_start", {31'd0, busy}, 32'd1);
        tick(30);
        chk("glitch_busy_after", {31'd0, busy}, 32'd0);
        chk("glitch_byte_kept", {24'd0, rx_byte}, 32'hA5);

        // 0x3C with low stop bit, then break held 40 bit times
        send_frame(8'h3C, 1'b0, 16, 1'b1, 1'b1, 8'hA5, 155);
        tick(320);
        chk("break_busy_mid", {31'd0, busy}, 32'd0);
        tick(320);
        chk("break_busy_end", {31'd0, busy}, 32'd0);
        chk("break_byte_kept", {24'd0, rx_byte}, 32'hA5);
        rx = 1'b1;
        tick(20);
        send_frame(8'h5A, 1'b1, 16, 1'b1, 1'b0, 8'h5A, 155);
        tick(20);

        // Back-to-back at div=4: latency 3 + 2 + 36 = 41
        baud_div = 16'd4;
        send_frame(8'h00, 1'b1, 4, 1'b1, 1'b0, 8'h00, 41);
        send_frame(8'hFF, 1'b1, 4, 1'b1, 1'b0, 8'hFF, 41);
        send_frame(8'h55, 1'b1, 4, 1'b1, 1'b0, 8'h55, 41);
        tick(20);
        chk("b2b4_byte_last", {24'd0, rx_byte}, 32'h55);

        // div=0 clamps to 2: latency 3 + 1 + 18 = 22
        baud_div = 16'd0;
        send_frame(8'h00, 1'b1, 2, 1'b1, 1'b0, 8'h00, 22);
        send_frame(8'hFF, 1'b1, 2, 1'b1, 1'b0, 8'hFF, 22);
        send_frame(8'h55, 1'b1, 2, 1'b1, 1'b0, 8'h55, 22);
        tick(20);
        chk("b2b2_busy_after", {31'd0, busy}, 32'd0);

        // Divisor change after the start bit must not affect the frame in flight
        baud_div = 16'd16;
        hook_bit = 1; hook_act = 1;
        send_frame(8'h96, 1'b1, 16, 1'b1, 1'b0, 8'h96, 155);
        hook_bit = -1;
        baud_div = 16'd16;
        tick(20);

        // Enable dropped during data bit 3: abort, no pulse, byte kept
        hook_bit = 4; hook_act = 2;
        send_frame(8'hA5, 1'b1, 16, 1'b0, 1'b0, 8'h00, -1);
        hook_bit = -1;
        tick(5);
        chk("endrop_busy", {31'd0, busy}, 32'd0);
        chk("endrop_byte_kept", {24'd0, rx_byte}, 32'h96);
        en = 1'b1;
        tick(20);

        // Reset during data bit 5, released two bit times later; high tail bits give no new edge
        hook_bit = 6; hook_act = 3;
        send_frame(8'hC3, 1'b1, 16, 1'b0, 1'b0, 8'h00, -1);
        hook_bit = -1;
        tick(40);
        chk("rst_after_byte", {24'd0, rx_byte}, 32'd0);
        chk("rst_after_busy", {31'd0, busy}, 32'd0);

        send_frame(8'h0F, 1'b1, 16, 1'b1, 1'b0, 8'h0F, 155);
        tick(30);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
